// File: rtl/trig_pkg.sv
// Shared encodings for the trigger sequence decoder: FSM states, error codes, run widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trig_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_L1 = 2'd1,
        S_WAIT_L2 = 2'd2
    } trig_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_WIDTH = 2'd1,
        ERR_L1WIN = 2'd2,
        ERR_UNEXP = 2'd3
    } err_code_t;

    // High-run widths on the combined trigger line; the width counter saturates at W_SAT.
    localparam logic [1:0] W_L0  = 2'd1;
    localparam logic [1:0] W_L1  = 2'd2;
    localparam logic [1:0] W_SAT = 2'd3;

    localparam logic [15:0] LAT_MAX = 16'hFFFF;

endpackage

// File: rtl/trig_pulse_width_dec.sv
// Classifies each high run on trig_in as L0 (1 cycle), L1 (2 cycles) or bad width (>=3).
// Latency: pulse registered on the edge that samples the first low after the run.
// Backpressure: none; the trigger line cannot be stalled.
module trig_pulse_width_dec
    import trig_pkg::*;
(
    input  logic gclk_40m,
    input  logic reset,
    input  logic trig_in,
    output logic is_l0,
    output logic is_l1,
    output logic bad_width
);

    logic [1:0] width;

    // Count the current high run (saturating) and classify it when the line drops.
    always_ff @(posedge gclk_40m) begin
        if (reset) begin
            width     <= 2'd0;
            is_l0     <= 1'b0;
            is_l1     <= 1'b0;
            bad_width <= 1'b0;
        end else begin
            is_l0     <= 1'b0;
            is_l1     <= 1'b0;
            bad_width <= 1'b0;
            if (trig_in) begin
                if (width != W_SAT) begin
                    width <= width + 2'd1;
                end
            end else begin
                width     <= 2'd0;
                is_l0     <= (width == W_L0);
                is_l1     <= (width == W_L1);
                bad_width <= (width == W_SAT);
            end
        end
    end

endmodule

// File: rtl/trig_seq_decoder.sv
// Decodes the L0 -> L1 -> L2 accept/reject trigger sequence and flags protocol errors.
// Latency: decoded pulses appear one cycle after the classifier pulse; all outputs registered.
// Backpressure: none; every trigger is decoded or reported as an error.
module trig_seq_decoder
    import trig_pkg::*;
(
    input  logic        gclk_40m,
    input  logic        reset,
    input  logic        trig_in,
    input  logic        l2a_in,
    input  logic [15:0] l1_lat_min,
    input  logic [15:0] l1_lat_max,
    input  logic [15:0] l2_timeout,
    output logic        l0_det,
    output logic        l1_det,
    output logic        l2a_det,
    output logic        l2r_det,
    output logic        busy,
    output logic        seq_err,
    output logic [1:0]  err_code,
    output logic [15:0] evt_cnt
);

    logic        is_l0;
    logic        is_l1;
    logic        bad_width;

    trig_state_t state_q, state_d;
    logic [15:0] lat_q, lat_d, lat_inc;
    logic [15:0] evt_q, evt_d;
    err_code_t   err_q, err_d, fsm_err;
    logic        l0_d, l1_d, l2a_d, l2r_d;

    trig_pulse_width_dec u_width_dec (
        .gclk_40m  (gclk_40m),
        .reset     (reset),
        .trig_in   (trig_in),
        .is_l0     (is_l0),
        .is_l1     (is_l1),
        .bad_width (bad_width)
    );

    // Next-state, latency counter and pulse decisions for the sequence FSM.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        evt_d   = evt_q;
        l0_d    = 1'b0;
        l1_d    = 1'b0;
        l2a_d   = 1'b0;
        l2r_d   = 1'b0;
        fsm_err = ERR_NONE;
        lat_inc = (lat_q == LAT_MAX) ? lat_q : lat_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (is_l0) begin
                    l0_d    = 1'b1;
                    lat_d   = 16'd0;
                    state_d = S_WAIT_L1;
                end
                if (is_l1 || l2a_in) begin
                    fsm_err = ERR_UNEXP;
                end
            end
            S_WAIT_L1: begin
                lat_d = lat_inc;
                if (is_l1) begin
                    if (lat_q >= l1_lat_min && lat_q <= l1_lat_max) begin
                        l1_d    = 1'b1;
                        lat_d   = 16'd0;
                        state_d = S_WAIT_L2;
                    end else begin
                        fsm_err = ERR_L1WIN;
                        state_d = S_IDLE;
                    end
                end else if (lat_q > l1_lat_max) begin
                    fsm_err = ERR_L1WIN;
                    state_d = S_IDLE;
                end
                // A stray L0/L2a is reported but never masks a window error.
                if ((is_l0 || l2a_in) && fsm_err == ERR_NONE) begin
                    fsm_err = ERR_UNEXP;
                end
            end
            S_WAIT_L2: begin
                lat_d = lat_inc;
                // Accept wins over a timeout landing in the same cycle.
                if (l2a_in) begin
                    l2a_d   = 1'b1;
                    evt_d   = evt_q + 16'd1;
                    state_d = S_IDLE;
                end else if (lat_q == l2_timeout) begin
                    l2r_d   = 1'b1;
                    state_d = S_IDLE;
                end
                if (is_l0 || is_l1) begin
                    fsm_err = ERR_UNEXP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A malformed trigger outranks any sequencing error in the same cycle.
        err_d = bad_width ? ERR_WIDTH : fsm_err;
    end

    // State, counters and registered outputs.
    always_ff @(posedge gclk_40m) begin
        if (reset) begin
            state_q <= S_IDLE;
            lat_q   <= 16'd0;
            evt_q   <= 16'd0;
            err_q   <= ERR_NONE;
            l0_det  <= 1'b0;
            l1_det  <= 1'b0;
            l2a_det <= 1'b0;
            l2r_det <= 1'b0;
            busy    <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            evt_q   <= evt_d;
            l0_det  <= l0_d;
            l1_det  <= l1_d;
            l2a_det <= l2a_d;
            l2r_det <= l2r_d;
            busy    <= (state_d != S_IDLE);
            seq_err <= (err_d != ERR_NONE);
            if (err_d != ERR_NONE) begin
                err_q <= err_d;
            end
        end
    end

    assign err_code = err_q;
    assign evt_cnt  = evt_q;

endmodule

// File: tb/tb_trig_seq_decoder.sv
// Directed bench for trig_seq_decoder: a timestamp/run-length model is compared every cycle,
// and literal cycle numbers and counts pin the model for each scenario.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
`timescale 1ns/100ps
module tb_trig_seq_decoder;

    logic        gclk_40m = 1'b0;
    logic        reset = 1'b1;
    logic        trig_in = 1'b0;
    logic        l2a_in = 1'b0;
    logic [15:0] l1_lat_min = 16'd5;
    logic [15:0] l1_lat_max = 16'd10;
    logic [15:0] l2_timeout = 16'd20;
    logic        l0_det, l1_det, l2a_det, l2r_det, busy, seq_err;
    logic [1:0]  err_code;
    logic [15:0] evt_cnt;

    trig_seq_decoder dut (
        .gclk_40m   (gclk_40m),
        .reset      (reset),
        .trig_in    (trig_in),
        .l2a_in     (l2a_in),
        .l1_lat_min (l1_lat_min),
        .l1_lat_max (l1_lat_max),
        .l2_timeout (l2_timeout),
        .l0_det     (l0_det),
        .l1_det     (l1_det),
        .l2a_det    (l2a_det),
        .l2r_det    (l2r_det),
        .busy       (busy),
        .seq_err    (seq_err),
        .err_code   (err_code),
        .evt_cnt    (evt_cnt)
    );

    always #12.5 gclk_40m = ~gclk_40m;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    bit preset_evt = 1'b0;

    // Model state: length of the current high run, class waiting one cycle in the
    // classifier, sequence phase (0 idle, 1 awaiting L1, 2 awaiting L2) and the
    // cycle at which the current phase was entered.
    int m_run = 0;
    int m_pend = 0;   // 0 none, 1 L0, 2 L1, 3 bad width
    int m_phase = 0;
    int m_t0 = 0;
    int cls, fe, v;
    logic        e_l0, e_l1, e_l2a, e_l2r, e_busy, e_seq;
    logic [1:0]  e_err;
    logic [15:0] e_evt;

    // Pulse history seen on the DUT, used by the literal checks.
    int n_l0 = 0, n_l1 = 0, n_l2a = 0, n_l2r = 0, n_err = 0;
    int t_l0 = -1, t_l1 = -1, t_l2a = -1, t_l2r = -1, t_err = -1;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", name, got, exp);
    endtask

    // Model step on every rising edge, then a full-output comparison 1 ns later.
    always @(posedge gclk_40m) begin
        cyc++;
        e_l0 = 0; e_l1 = 0; e_l2a = 0; e_l2r = 0; e_seq = 0;
        if (reset) begin
            m_run = 0; m_pend = 0; m_phase = 0;
            e_err = 0; e_evt = 0; e_busy = 0;
        end else begin
            if (preset_evt) e_evt = 16'hFFFF;
            cls = m_pend;
            m_pend = 0;
            if (trig_in) m_run++;
            else begin
                if (m_run == 1) m_pend = 1;
                else if (m_run == 2) m_pend = 2;
                else if (m_run >= 3) m_pend = 3;
                m_run = 0;
            end
            v = cyc - m_t0 - 1;
            if (v > 65535) v = 65535;
            fe = 0;
            case (m_phase)
                0: begin
                    if (cls == 1) begin e_l0 = 1; m_phase = 1; m_t0 = cyc; end
                    if (cls == 2 || l2a_in) fe = 3;
                end
                1: begin
                    if (cls == 2) begin
                        if (v >= int'(l1_lat_min) && v <= int'(l1_lat_max)) begin
                            e_l1 = 1; m_phase = 2; m_t0 = cyc;
                        end else begin
                            fe = 2; m_phase = 0;
                        end
                    end else if (v > int'(l1_lat_max)) begin
                        fe = 2; m_phase = 0;
                    end
                    if ((cls == 1 || l2a_in) && fe == 0) fe = 3;
                end
                default: begin
                    if (l2a_in) begin e_l2a = 1; e_evt = e_evt + 16'd1; m_phase = 0; end
                    else if (v == int'(l2_timeout)) begin e_l2r = 1; m_phase = 0; end
                    if (cls == 1 || cls == 2) fe = 3;
                end
            endcase
            if (cls == 3) begin e_seq = 1; e_err = 2'd1; end
            else if (fe != 0) begin e_seq = 1; e_err = 2'(fe); end
            e_busy = (m_phase != 0);
        end
        #1;
        total++;
        if ({l0_det, l1_det, l2a_det, l2r_det, busy, seq_err, err_code, evt_cnt} ===
            {e_l0, e_l1, e_l2a, e_l2r, e_busy, e_seq, e_err, e_evt}) begin
            passed++;
        end else begin
            $display("FAIL cycle%0d outputs: got l0=%b l1=%b l2a=%b l2r=%b busy=%b err=%b code=%0d evt=%0d want l0=%b l1=%b l2a=%b l2r=%b busy=%b err=%b code=%0d evt=%0d",
                     cyc, l0_det, l1_det, l2a_det, l2r_det, busy, seq_err, err_code, evt_cnt,
                     e_l0, e_l1, e_l2a, e_l2r, e_busy, e_seq, e_err, e_evt);
        end
        if (l0_det === 1'b1)  begin n_l0++;  t_l0 = cyc;  end
        if (l1_det === 1'b1)  begin n_l1++;  t_l1 = cyc;  end
        if (l2a_det === 1'b1) begin n_l2a++; t_l2a = cyc; end
        if (l2r_det === 1'b1) begin n_l2r++; t_l2r = cyc; end
        if (seq_err === 1'b1) begin n_err++; t_err = cyc; end
    end

    // Park on the falling edge just before rising edge c, so inputs set now are sampled at c.
    task automatic at(input int c);
        int g;
        g = 0;
        while (cyc < c - 1 && g < 5000) begin
            @(negedge gclk_40m);
            g++;
        end
        if (cyc != c - 1) begin
            total++;
            $display("FAIL schedule: at cycle %0d want %0d", cyc, c - 1);
        end
    endtask

    task automatic trig_run(input int c, input int w);
        at(c);
        trig_in = 1'b1;
        at(c + w);
        trig_in = 1'b0;
    endtask

    task automatic l2a_at(input int c);
        at(c);
        l2a_in = 1'b1;
        at(c + 1);
        l2a_in = 1'b0;
    endtask

    int n, m, b0, b1, b2, b3, b4;

    initial begin
        repeat (3) @(negedge gclk_40m);
        chk("reset_outputs", int'({l0_det, l1_det, l2a_det, l2r_det, busy, seq_err, err_code, evt_cnt}), 0);
        reset = 1'b0;

        // Good event: L1 at latency 7, accept 3 cycles after l1_det.
        n = cyc + 2; m = n + 7;
        trig_run(n, 1); trig_run(m, 2); l2a_at(m + 6); at(m + 12);
        chk("ok_l0_cycle", t_l0, n + 2);
        chk("ok_l1_cycle", t_l1, m + 3);
        chk("ok_l2a_cycle", t_l2a, m + 6);
        chk("ok_pulses", n_l0 * 100 + n_l1 * 10 + n_l2a, 111);
        chk("ok_evt", int'(evt_cnt), 1);
        chk("ok_busy", int'(busy), 0);

        // L0 without L1: window error once latency passes 10.
        n = cyc + 2; b0 = n_l1;
        trig_run(n, 1); at(n + 20);
        chk("nol1_err_cycle", t_err, n + 14);
        chk("nol1_code", int'(err_code), 2);
        chk("nol1_busy", int'(busy), 0);
        chk("nol1_no_l1", n_l1 - b0, 0);

        // L1 accepted, no accept: reject when latency reaches 20.
        n = cyc + 2; m = n + 7; b0 = n_l2a;
        trig_run(n, 1); trig_run(m, 2); at(m + 30);
        chk("tmo_l2r_cycle", t_l2r, m + 24);
        chk("tmo_evt", int'(evt_cnt), 1);
        chk("tmo_no_l2a", n_l2a - b0, 0);

        // Accept coincident with the timeout cycle.
        n = cyc + 2; m = n + 7; b0 = n_l2r;
        trig_run(n, 1); trig_run(m, 2); l2a_at(m + 24); at(m + 30);
        chk("coinc_l2a_cycle", t_l2a, m + 24);
        chk("coinc_no_l2r", n_l2r - b0, 0);
        chk("coinc_evt", int'(evt_cnt), 2);

        // Window edges: latency 10 accepted, latency 4 rejected.
        n = cyc + 2; m = n + 10;
        trig_run(n, 1); trig_run(m, 2); l2a_at(m + 5); at(m + 8);
        chk("win_max_l1_cycle", t_l1, m + 3);
        chk("win_max_evt", int'(evt_cnt), 3);
        n = cyc + 2; m = n + 4;
        trig_run(n, 1); trig_run(m, 2); at(m + 8);
        chk("win_min_err_cycle", t_err, m + 3);
        chk("win_min_code", int'(err_code), 2);

        // Bad width coincident with a stray accept in IDLE, then a bare L1 in IDLE.
        n = cyc + 2; b0 = n_l0; b1 = n_l1; b2 = n_err;
        trig_run(n, 3); l2a_at(n + 4); at(n + 8);
        chk("bad_err_cycle", t_err, n + 4);
        chk("bad_code", int'(err_code), 1);
        chk("bad_no_decode", (n_l0 - b0) + (n_l1 - b1), 0);
        chk("bad_err_pulses", n_err - b2, 1);
        n = cyc + 2;
        trig_run(n, 2); at(n + 6);
        chk("idle_l1_err_cycle", t_err, n + 3);
        chk("idle_l1_code", int'(err_code), 3);

        // Stray accept while waiting for L1 is reported but the sequence completes.
        n = cyc + 2; m = n + 7;
        trig_run(n, 1); l2a_at(n + 4); trig_run(m, 2); l2a_at(m + 5); at(m + 8);
        chk("stray_code", int'(err_code), 3);
        chk("stray_evt", int'(evt_cnt), 4);

        // Inverted window: every L1 is a window error.
        l1_lat_min = 16'd12; l1_lat_max = 16'd8;
        n = cyc + 2; m = n + 6; b0 = n_l1;
        trig_run(n, 1); trig_run(m, 2); at(m + 6);
        chk("inv_code", int'(err_code), 2);
        chk("inv_no_l1", n_l1 - b0, 0);
        l1_lat_min = 16'd5; l1_lat_max = 16'd10;

        // Event counter wrap from 16'hFFFF.
        at(cyc + 2);
        force dut.evt_q = 16'hFFFF;
        preset_evt = 1'b1;
        at(cyc + 2);
        release dut.evt_q;
        preset_evt = 1'b0;
        n = cyc + 2; m = n + 7; b0 = n_l2a;
        trig_run(n, 1); trig_run(m, 2); l2a_at(m + 6); at(m + 10);
        chk("wrap_evt", int'(evt_cnt), 0);
        chk("wrap_l2a", n_l2a - b0, 1);

        // Reset while waiting for L2, then a clean sequence.
        n = cyc + 2; m = n + 7; b0 = n_l2r; b1 = n_err;
        trig_run(n, 1); trig_run(m, 2); at(m + 6);
        reset = 1'b1;
        at(m + 7);
        chk("rst_outputs", int'({l0_det, l1_det, l2a_det, l2r_det, busy, seq_err, err_code, evt_cnt}), 0);
        at(m + 8);
        reset = 1'b0;
        at(m + 40);
        chk("rst_no_l2r", n_l2r - b0, 0);
        chk("rst_no_err", n_err - b1, 0);
        n = cyc + 2; m = n + 7; b3 = n_l1; b4 = n_l2a;
        trig_run(n, 1); trig_run(m, 2); l2a_at(m + 6); at(m + 10);
        chk("post_rst_l0_cycle", t_l0, n + 2);
        chk("post_rst_pulses", (n_l1 - b3) * 10 + (n_l2a - b4), 11);
        chk("post_rst_evt", int'(evt_cnt), 1);

        at(cyc + 3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
